// File: rtl/urng_pair_if.sv
// Bundle between the tausworthe URNG word stream, the pair FIFO head and the
// Box-Muller consumer. The master drives the URNG words and the ready strobe.
interface urng_pair_if #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [31:0]      y;
  logic             y_valid;
  logic [47:0]      u0;
  logic [15:0]      u1;
  logic             uv_valid;
  logic             uv_ready;
  logic [LVL_W-1:0] level;
  logic [CNT_W-1:0] drop_count;
  logic             warm;

  modport master (
    output y, y_valid, uv_ready,
    input  u0, u1, uv_valid, level, drop_count, warm
  );

  modport slave (
    input  y, y_valid, uv_ready,
    output u0, u1, uv_valid, level, drop_count, warm
  );
endinterface

// File: rtl/urng_pair_reader.sv
// Repacks the free-running 32-bit URNG word stream into (u0,u1) pairs after a
// warm-up skip, buffering them in a small FIFO; pairs finding it full are dropped.
module urng_pair_reader #(
  parameter int DEPTH      = 4,
  parameter int SKIP_WORDS = 8,
  parameter int CNT_W      = 16
) (
  input  logic      clk,
  input  logic      reset,
  urng_pair_if.slave bus
);
  localparam int AW     = $clog2(DEPTH);
  localparam int LVL_W  = $clog2(DEPTH) + 1;
  localparam int SKIP_W = (SKIP_WORDS > 0) ? $clog2(SKIP_WORDS + 1) : 1;
  localparam logic [SKIP_W-1:0] SKIP_INIT = SKIP_W'(SKIP_WORDS);
  localparam logic [LVL_W-1:0]  FULL_LVL  = LVL_W'(DEPTH);

  typedef enum logic [1:0] {WARMUP, EVEN, ODD} state_t;

  state_t            state, state_nx;
  logic [SKIP_W-1:0] skip_cnt, skip_cnt_nx;
  logic              warm_r, warm_nx;
  logic              latch_a, push;
  logic [31:0]       word_a;

  logic [63:0]       mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [LVL_W-1:0]  count;
  logic [CNT_W-1:0]  drops;
  logic              pop, full, accept, drop;
  logic [63:0]       head;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Assembler: warm-up skip, then alternate A / B words on each valid word
  always_comb begin
    state_nx    = state;
    skip_cnt_nx = skip_cnt;
    latch_a     = 1'b0;
    push        = 1'b0;
    if (bus.y_valid) begin
      case (state)
        WARMUP: begin
          if (skip_cnt <= SKIP_W'(1)) state_nx = EVEN;
          if (skip_cnt != '0) skip_cnt_nx = skip_cnt - 1'b1;
        end
        EVEN: begin
          latch_a  = 1'b1;
          state_nx = ODD;
        end
        ODD: begin
          push     = 1'b1;
          state_nx = EVEN;
        end
        default: state_nx = EVEN;
      endcase
    end
    warm_nx = (state_nx != WARMUP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= (SKIP_WORDS == 0) ? EVEN : WARMUP;
      skip_cnt <= SKIP_INIT;
      warm_r   <= 1'b0;
    end else begin
      state    <= state_nx;
      skip_cnt <= skip_cnt_nx;
      warm_r   <= warm_nx;
    end
  end

  // A partial pair left by reset is harmless: the FSM always relatches A first.
  always_ff @(posedge clk) begin
    if (latch_a) word_a <= bus.y;
  end

  // FIFO: push on the B edge, pop on handshake; pop frees a slot for a same-edge push
  assign pop    = (count != '0) && bus.uv_ready;
  assign full   = (count == FULL_LVL);
  assign accept = push && (!full || pop);
  assign drop   = push && !accept;

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= {word_a, bus.y};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      drops  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) drops <= sat_inc(drops);
    end
  end

  // Output head, zeroed while nothing is held
  assign head           = mem[rd_ptr];
  assign bus.uv_valid   = (count != '0);
  assign bus.u0         = bus.uv_valid ? head[63:16] : '0;
  assign bus.u1         = bus.uv_valid ? head[15:0]  : '0;
  assign bus.level      = count;
  assign bus.drop_count = drops;
  assign bus.warm       = warm_r;

  a_level_range: assert property (@(posedge clk) disable iff (reset) count <= FULL_LVL);
  a_push_excl:   assert property (@(posedge clk) disable iff (reset) !(accept && drop));
endmodule

// File: tb/tb_urng_pair_reader.sv
// Bench for urng_pair_reader: vector table, hand-written corner sequences and a
// tausworthe-driven random run scored against a queue model of pairing.
module tb_urng_pair_reader;
  localparam int DEPTH = 4;
  localparam int SKIP  = 8;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  urng_pair_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  urng_pair_reader #(.DEPTH(DEPTH), .SKIP_WORDS(SKIP), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // reference model state
  int          m_words;
  logic [31:0] m_a;
  logic [63:0] m_q[$];
  int          m_drops;

  typedef struct {
    logic        r;
    logic        yv;
    logic [31:0] y;
    logic        rdy;
    logic        ev;
    logic [47:0] eu0;
    logic [15:0] eu1;
    logic [2:0]  elvl;
    logic        ewarm;
  } vec_t;

  vec_t tbl[19];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_edge();
    int k;
    if (reset) begin
      m_words = 0;
      m_q.delete();
      m_drops = 0;
    end else begin
      if (m_q.size() > 0 && bus.uv_ready) void'(m_q.pop_front());
      if (bus.y_valid) begin
        m_words++;
        if (m_words > SKIP) begin
          k = m_words - SKIP;
          if (k % 2 == 1) m_a = bus.y;
          else if (m_q.size() < DEPTH) m_q.push_back({m_a, bus.y});
          else if (m_drops < (1 << CNT_W) - 1) m_drops++;
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic yv, input logic [31:0] yy, input logic rdy);
    reset        = r;
    bus.y_valid  = yv;
    bus.y        = yy;
    bus.uv_ready = rdy;
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_valid"}, 64'(bus.uv_valid), 64'(m_q.size() != 0));
    check({tag, "_level"}, 64'(bus.level), 64'(m_q.size()));
    check({tag, "_drops"}, 64'(bus.drop_count), 64'(m_drops));
    check({tag, "_warm"},  64'(bus.warm), 64'(m_words >= SKIP));
    if (m_q.size() != 0) check({tag, "_pair"}, {bus.u0, bus.u1}, m_q[0]);
  endtask

  function automatic logic [31:0] taus_next(input logic [31:0] s);
    logic [31:0] b;
    b = ((s << 13) ^ s) >> 19;
    return ((s & 32'hFFFF_FFFE) << 12) ^ b;
  endfunction

  initial begin
    logic [63:0] exp_order[4];
    logic [31:0] s;
    logic        rdy;

    // vectors: reset, warm-up with counting words, first pair, then A/gap/B
    tbl[0] = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 48'h0, 16'h0, 3'd0, 1'b0};
    for (int i = 1; i <= 8; i++)
      tbl[i] = '{1'b0, 1'b1, 32'(i), 1'b0, 1'b0, 48'h0, 16'h0, 3'd0, (i == 8)};
    tbl[9]  = '{1'b0, 1'b1, 32'd9,  1'b0, 1'b0, 48'h0, 16'h0, 3'd0, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 32'd10, 1'b0, 1'b1, 48'h0000_0009_0000, 16'h000A, 3'd1, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 32'd11, 1'b0, 1'b1, 48'h0000_0009_0000, 16'h000A, 3'd1, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 32'd0,  1'b1, 1'b0, 48'h0, 16'h0, 3'd0, 1'b1};
    tbl[13] = '{1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 48'h0, 16'h0, 3'd0, 1'b1};
    for (int i = 14; i <= 16; i++)
      tbl[i] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 48'h0, 16'h0, 3'd0, 1'b1};
    tbl[17] = '{1'b0, 1'b1, 32'h1234_5678, 1'b1, 1'b1, 48'hDEAD_BEEF_1234, 16'h5678, 3'd1, 1'b1};
    tbl[18] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 48'h0, 16'h0, 3'd0, 1'b1};

    for (int i = 0; i < 19; i++) begin
      step(tbl[i].r, tbl[i].yv, tbl[i].y, tbl[i].rdy);
      check($sformatf("vec%0d_valid", i), 64'(bus.uv_valid), 64'(tbl[i].ev));
      check($sformatf("vec%0d_level", i), 64'(bus.level), 64'(tbl[i].elvl));
      check($sformatf("vec%0d_warm", i),  64'(bus.warm), 64'(tbl[i].ewarm));
      check($sformatf("vec%0d_drops", i), 64'(bus.drop_count), 64'd0);
      if (i == 0 || tbl[i].ev) begin
        check($sformatf("vec%0d_u0", i), 64'(bus.u0), 64'(tbl[i].eu0));
        check($sformatf("vec%0d_u1", i), 64'(bus.u1), 64'(tbl[i].eu1));
      end
    end

    // fill with ready low: 6 pairs into 4 slots
    step(1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 1; i <= SKIP; i++) step(1'b0, 1'b1, 32'(i), 1'b0);
    for (int k = 1; k <= 12; k++) step(1'b0, 1'b1, 32'h100 + 32'(k), 1'b0);
    check("full_level", 64'(bus.level), 64'd4);
    check("full_drops", 64'(bus.drop_count), 64'd2);
    check("full_valid", 64'(bus.uv_valid), 64'd1);
    check("full_head",  {bus.u0, bus.u1}, {32'h101, 32'h102});

    // full: A arrives, then B on the same edge as a pop
    step(1'b0, 1'b1, 32'h10D, 1'b0);
    check("fullA_level", 64'(bus.level), 64'd4);
    check("fullA_head",  {bus.u0, bus.u1}, {32'h101, 32'h102});
    step(1'b0, 1'b1, 32'h10E, 1'b1);
    check("pushpop_drops", 64'(bus.drop_count), 64'd2);
    check("pushpop_level", 64'(bus.level), 64'd4);

    exp_order[0] = {32'h103, 32'h104};
    exp_order[1] = {32'h105, 32'h106};
    exp_order[2] = {32'h107, 32'h108};
    exp_order[3] = {32'h10D, 32'h10E};
    for (int j = 0; j < 4; j++) begin
      check($sformatf("drain%0d_pair", j), {bus.u0, bus.u1}, exp_order[j]);
      check($sformatf("drain%0d_valid", j), 64'(bus.uv_valid), 64'd1);
      step(1'b0, 1'b0, 32'h0, 1'b1);
    end
    check("drained_valid", 64'(bus.uv_valid), 64'd0);
    check("drained_level", 64'(bus.level), 64'd0);

    // reset after A latched mid-stream
    for (int i = 1; i <= SKIP; i++) step(1'b0, 1'b1, 32'h200 + 32'(i), 1'b0);
    step(1'b0, 1'b1, 32'hAAAA_0001, 1'b0);
    step(1'b1, 1'b1, 32'hAAAA_0002, 1'b0);
    check("rst_valid", 64'(bus.uv_valid), 64'd0);
    check("rst_level", 64'(bus.level), 64'd0);
    check("rst_warm",  64'(bus.warm), 64'd0);
    check("rst_drops", 64'(bus.drop_count), 64'd0);
    check("rst_u0",    64'(bus.u0), 64'd0);
    check("rst_u1",    64'(bus.u1), 64'd0);
    for (int i = 1; i <= SKIP; i++) begin
      step(1'b0, 1'b1, 32'h300 + 32'(i), 1'b0);
      check($sformatf("rewarm%0d", i), 64'(bus.warm), 64'(i == SKIP));
      check($sformatf("rewarm%0d_valid", i), 64'(bus.uv_valid), 64'd0);
    end
    step(1'b0, 1'b1, 32'hBBBB_0001, 1'b0);
    step(1'b0, 1'b1, 32'hCCCC_0002, 1'b0);
    check("post_rst_valid", 64'(bus.uv_valid), 64'd1);
    check("post_rst_u0",    64'(bus.u0), 64'hBBBB_0001_CCCC);
    check("post_rst_u1",    64'(bus.u1), 64'h0002);

    // tausworthe stream with random back-pressure against the model
    s = 32'h0006_7580;
    step(1'b1, 1'b0, 32'h0, 1'b0);
    check_model("rnd_rst");
    for (int c = 0; c < 3000; c++) begin
      s   = taus_next(s);
      rdy = 1'($urandom_range(0, 1));
      step(1'b0, 1'b1, s, rdy);
      check_model($sformatf("rnd%0d", c));
    end
    check("rnd_final_drops", 64'(bus.drop_count), 64'(m_drops));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
